cd_cfg_sequencer: RTL and testbench
===================================

Name: cd_cfg_sequencer

Overview:
- Upstream configuration master for the clock divider's config port; drives its c_addr/c_data/c_valid and consumes its c_ready.
- Parses framed byte commands from the UART receiver: SYNC, ADDR, DATA bytes MSB first, XOR checksum.
- Issues one config write per valid frame, then returns a one-byte ACK/NAK to the UART transmitter.
- Runs on the system clock; the UART side is a byte-valid strobe interface.

Parameters:
- WIDTH_CONFIG_ADDR, 4, config address width; must be 8 or less.
- WIDTH_CONFIG_DATA, 16, config data width; must be a multiple of 8 and 32 or less.
- SYNC_BYTE, 8'hA5, frame start marker.
- ACK_BYTE, 8'h06, response for a frame that was written.
- NAK_BYTE, 8'h15, response for a rejected frame.
- TIMEOUT_CYCLES, 100000, maximum clk cycles between bytes within a frame.
- WIDTH_TIMEOUT, 17, timeout counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- c_addr  out  WIDTH_CONFIG_ADDR  config address
- c_data  out  WIDTH_CONFIG_DATA  config data
- c_valid  out  1  config write request
- c_ready  in  1  config target ready
- tx_data  out  8  response byte
- tx_valid  out  1  response request
- tx_ready  in  1  transmitter accepts byte
- busy  out  1  high in any state other than IDLE
- err_cnt  out  8  saturating count of NAKs plus timeouts

Behaviour:
- Reset is synchronous, active-low, with one clock: on clk rising edge with rst_n=0, go to IDLE.
- Reset values: c_valid=0, tx_valid=0, c_addr=0, c_data=0, tx_data=0, err_cnt=0, busy=0, timeout counter=0, checksum accumulator=0.
- States: IDLE, ADDR, DATA, CSUM, ISSUE, RESP.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE -> ADDR; clear the checksum accumulator.
  - Any other byte is discarded.
- ADDR:
  - On rx_valid, latch the byte and XOR it into the accumulator.
  - Set the address-error flag if any bit at or above WIDTH_CONFIG_ADDR is 1.
  - Go to DATA with the byte counter = 0.
- DATA:
  - Each rx_valid shifts the byte into the data register (MSB first) and XORs it into the accumulator.
  - After the byte with index WIDTH_CONFIG_DATA/8-1, go to CSUM.
- CSUM, on rx_valid:
  - Accumulator == rx_data and no address error -> ISSUE. Drive c_addr and c_data from the latched values; c_valid=1 on the next cycle.
  - Otherwise -> RESP with tx_data=NAK_BYTE; err_cnt+1.
- ISSUE:
  - Hold c_valid=1 with c_addr/c_data stable until a cycle with c_valid&c_ready=1. That is the transfer cycle.
  - c_valid drops on the following cycle.
  - The FSM moves to RESP with tx_data=ACK_BYTE.
  - If c_ready is already 1, the transfer occurs in the first ISSUE cycle.
  - ISSUE has no timeout.
- RESP:
  - tx_valid=1 with tx_data stable until tx_valid&tx_ready=1, then -> IDLE and tx_valid=0 next cycle.
- Timeout:
  - In ADDR, DATA and CSUM the counter increments every cycle and clears on each rx_valid.
  - When it reaches TIMEOUT_CYCLES-1 without rx_valid: go to IDLE, increment err_cnt, send no response.
  - rx_valid in the same cycle as expiry: the byte is accepted and the timeout is cancelled.
- rx_valid during ISSUE or RESP: the byte is dropped and is not counted. A SYNC arriving then does not start a frame.
- A SYNC_BYTE value inside ADDR, DATA or CSUM is treated as data; there is no resync.
- err_cnt saturates at 8'hFF.
- Reset during ISSUE or RESP abandons the transfer: c_valid and tx_valid are 0 on the cycle after the reset edge.
- Latency: last byte (CSUM) strobe -> c_valid high is 1 cycle. Transfer cycle -> tx_valid high is 1 cycle.

Test Plan:
- Good frame: rx bytes A5,01,00,1B,1A with c_ready=1 -> exactly one transfer cycle with c_addr=1, c_data=16'h001B; then tx_data=8'h06 with tx_valid until tx_ready; err_cnt stays 0.
- Backpressure: same frame with c_ready=0 for 50 cycles, then 1 -> c_valid high for 51 cycles, c_addr/c_data unchanged throughout; tx_ready=0 for 10 cycles -> tx_valid held, tx_data=8'h06 stable.
- Checksum error: A5,01,00,1B,FF -> c_valid never asserted; tx_data=8'h15; err_cnt=1.
- Address range: A5,12,00,05,17 (checksum correct) -> NAK, no config write; err_cnt increments.
- Timeout: A5,01 then idle for TIMEOUT_CYCLES -> return to IDLE, err_cnt+1, no tx_valid; a following good frame is written normally.
- Reset and drop: rst_n=0 for 1 cycle during ISSUE -> c_valid=0 and busy=0 on the next cycle. Byte A5 sent during RESP is ignored -> FSM returns to IDLE after ACK, not ADDR.

Source files
------------

// File: rtl/cd_cfg_sequencer.sv
// Byte-framed configuration master: parses SYNC/ADDR/DATA/CSUM frames from a UART
// receiver, issues one config write per valid frame and answers with ACK or NAK.
module cd_cfg_sequencer #(
  parameter int unsigned WIDTH_CONFIG_ADDR = 4,
  parameter int unsigned WIDTH_CONFIG_DATA = 16,
  parameter logic [7:0]  SYNC_BYTE         = 8'hA5,
  parameter logic [7:0]  ACK_BYTE          = 8'h06,
  parameter logic [7:0]  NAK_BYTE          = 8'h15,
  parameter int unsigned TIMEOUT_CYCLES    = 100000,
  parameter int unsigned WIDTH_TIMEOUT     = 17
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
  output logic [WIDTH_CONFIG_DATA-1:0] c_data,
  output logic                         c_valid,
  input  logic                         c_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic [7:0]                   err_cnt
);

  localparam int unsigned NBYTES = WIDTH_CONFIG_DATA / 8;
  localparam logic [1:0] LAST_BYTE = 2'(NBYTES - 1);
  localparam logic [WIDTH_TIMEOUT-1:0] TMO_LAST = WIDTH_TIMEOUT'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_CSUM, S_ISSUE, S_RESP
  } state_t;

  state_t                       state_q, state_d;
  logic [WIDTH_CONFIG_ADDR-1:0] addr_q, addr_d;
  logic [WIDTH_CONFIG_DATA-1:0] data_q, data_d;
  logic [7:0]                   csum_q, csum_d;
  logic                         aerr_q, aerr_d;
  logic [1:0]                   bcnt_q, bcnt_d;
  logic [WIDTH_TIMEOUT-1:0]     tmo_q, tmo_d;
  logic [WIDTH_CONFIG_ADDR-1:0] c_addr_q, c_addr_d;
  logic [WIDTH_CONFIG_DATA-1:0] c_data_q, c_data_d;
  logic                         c_valid_q, c_valid_d;
  logic [7:0]                   tx_data_q, tx_data_d;
  logic                         tx_valid_q, tx_valid_d;
  logic [7:0]                   err_q, err_d;
  logic [7:0]                   err_inc;

  assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      csum_q     <= '0;
      aerr_q     <= 1'b0;
      bcnt_q     <= '0;
      tmo_q      <= '0;
      c_addr_q   <= '0;
      c_data_q   <= '0;
      c_valid_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      csum_q     <= csum_d;
      aerr_q     <= aerr_d;
      bcnt_q     <= bcnt_d;
      tmo_q      <= tmo_d;
      c_addr_q   <= c_addr_d;
      c_data_q   <= c_data_d;
      c_valid_q  <= c_valid_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    csum_d     = csum_q;
    aerr_d     = aerr_q;
    bcnt_d     = bcnt_q;
    tmo_d      = tmo_q;
    c_addr_d   = c_addr_q;
    c_data_d   = c_data_q;
    c_valid_d  = c_valid_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = S_ADDR;
          csum_d  = '0;
          tmo_d   = '0;
        end
      end

      S_ADDR, S_DATA, S_CSUM: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (rx_valid) begin
          tmo_d = '0;
          unique case (state_q)
            S_ADDR: begin
              addr_d  = rx_data[WIDTH_CONFIG_ADDR-1:0];
              aerr_d  = |(rx_data >> WIDTH_CONFIG_ADDR);
              csum_d  = csum_q ^ rx_data;
              bcnt_d  = '0;
              state_d = S_DATA;
            end
            S_DATA: begin
              data_d = (data_q << 8) | WIDTH_CONFIG_DATA'(rx_data);
              csum_d = csum_q ^ rx_data;
              bcnt_d = bcnt_q + 2'd1;
              if (bcnt_q == LAST_BYTE) state_d = S_CSUM;
            end
            default: begin
              if (csum_q == rx_data && !aerr_q) begin
                state_d   = S_ISSUE;
                c_addr_d  = addr_q;
                c_data_d  = data_q;
                c_valid_d = 1'b1;
              end else begin
                state_d    = S_RESP;
                tx_data_d  = NAK_BYTE;
                tx_valid_d = 1'b1;
                err_d      = err_inc;
              end
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          tmo_d   = '0;
          err_d   = err_inc;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_ISSUE: begin
        if (c_ready) begin
          c_valid_d  = 1'b0;
          state_d    = S_RESP;
          tx_data_d  = ACK_BYTE;
          tx_valid_d = 1'b1;
        end
      end

      S_RESP: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign c_addr   = c_addr_q;
  assign c_data   = c_data_q;
  assign c_valid  = c_valid_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != S_IDLE);
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_cd_cfg_sequencer.sv
// Directed bench for cd_cfg_sequencer: a per-cycle vector table plus hand-written
// sequences for backpressure, timeout, reset-abort, drop-in-RESP and saturation.
module tb_cd_cfg_sequencer;

  localparam int unsigned TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [3:0]  c_addr;
  logic [15:0] c_data;
  logic        c_valid;
  logic        c_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [7:0]  err_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  cd_cfg_sequencer #(
    .TIMEOUT_CYCLES(TMO),
    .WIDTH_TIMEOUT (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .c_addr  (c_addr),
    .c_data  (c_data),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  typedef struct {
    logic        rxv;
    logic [7:0]  rxd;
    logic        cr;
    logic        tr;
    logic        busy;
    logic        cv;
    logic        tv;
    logic [7:0]  txd;
    logic [3:0]  ca;
    logic [15:0] cd;
    logic [7:0]  err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rxv, logic [7:0] rxd, logic cr, logic tr,
                              logic b, logic cv, logic tv, logic [7:0] txd,
                              logic [3:0] ca, logic [15:0] cd, logic [7:0] err);
    vec_t v;
    v.rxv = rxv; v.rxd = rxd; v.cr = cr; v.tr = tr;
    v.busy = b; v.cv = cv; v.tv = tv; v.txd = txd; v.ca = ca; v.cd = cd; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    int unsigned cv_cycles;
    logic [7:0]  e0;

    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; c_ready = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    chk("rst_c_valid", 32'(c_valid), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_c_addr", 32'(c_addr), 0);
    chk("rst_c_data", 32'(c_data), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;
    tick();

    // rxv rxd cr tr | busy cv tv txd ca cd err  (expected after the edge)
    vecs.push_back(mk(1, 8'hA5, 1, 0, 1, 0, 0, 8'h00, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 8'h01, 1, 0, 1, 0, 0, 8'h00, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 8'h1B, 1, 0, 1, 0, 0, 8'h00, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 8'h1A, 1, 0, 1, 1, 0, 8'h00, 1, 16'h001B, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 1, 8'h06, 1, 16'h001B, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 1, 8'h06, 1, 16'h001B, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 8'h06, 1, 16'h001B, 0));
    vecs.push_back(mk(1, 8'h01, 1, 1, 0, 0, 0, 8'h06, 1, 16'h001B, 0));
    vecs.push_back(mk(1, 8'hA5, 1, 0, 1, 0, 0, 8'h06, 1, 16'h001B, 0));
    vecs.push_back(mk(1, 8'h01, 1, 0, 1, 0, 0, 8'h06, 1, 16'h001B, 0));
    vecs.push_back(mk(1, 8'h00, 1, 0, 1, 0, 0, 8'h06, 1, 16'h001B, 0));
    vecs.push_back(mk(1, 8'h1B, 1, 0, 1, 0, 0, 8'h06, 1, 16'h001B, 0));
    vecs.push_back(mk(1, 8'hFF, 1, 0, 1, 0, 1, 8'h15, 1, 16'h001B, 1));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 8'h15, 1, 16'h001B, 1));
    vecs.push_back(mk(1, 8'hA5, 1, 0, 1, 0, 0, 8'h15, 1, 16'h001B, 1));
    vecs.push_back(mk(1, 8'h12, 1, 0, 1, 0, 0, 8'h15, 1, 16'h001B, 1));
    vecs.push_back(mk(1, 8'h00, 1, 0, 1, 0, 0, 8'h15, 1, 16'h001B, 1));
    vecs.push_back(mk(1, 8'h05, 1, 0, 1, 0, 0, 8'h15, 1, 16'h001B, 1));
    vecs.push_back(mk(1, 8'h17, 1, 0, 1, 0, 1, 8'h15, 1, 16'h001B, 2));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 8'h15, 1, 16'h001B, 2));
    vecs.push_back(mk(1, 8'hA5, 1, 0, 1, 0, 0, 8'h15, 1, 16'h001B, 2));
    vecs.push_back(mk(1, 8'h03, 1, 0, 1, 0, 0, 8'h15, 1, 16'h001B, 2));
    vecs.push_back(mk(1, 8'hA5, 1, 0, 1, 0, 0, 8'h15, 1, 16'h001B, 2));
    vecs.push_back(mk(1, 8'h00, 1, 0, 1, 0, 0, 8'h15, 1, 16'h001B, 2));
    vecs.push_back(mk(1, 8'hA6, 1, 0, 1, 1, 0, 8'h15, 3, 16'hA500, 2));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 1, 8'h06, 3, 16'hA500, 2));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 8'h06, 3, 16'hA500, 2));

    for (int i = 0; i < vecs.size(); i++) begin
      rx_valid = vecs[i].rxv; rx_data = vecs[i].rxd;
      c_ready  = vecs[i].cr;  tx_ready = vecs[i].tr;
      tick();
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_c_valid", i), 32'(c_valid), 32'(vecs[i].cv));
      chk($sformatf("vec%0d_tx_valid", i), 32'(tx_valid), 32'(vecs[i].tv));
      chk($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].txd));
      chk($sformatf("vec%0d_c_addr", i), 32'(c_addr), 32'(vecs[i].ca));
      chk($sformatf("vec%0d_c_data", i), 32'(c_data), 32'(vecs[i].cd));
      chk($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), 32'(vecs[i].err));
    end
    rx_valid = 1'b0; rx_data = 8'h00;

    // Backpressure on both handshakes
    c_ready = 1'b0; tx_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h1B); send_byte(8'h1A);
    cv_cycles = 0;
    for (int i = 0; i < 50; i++) begin
      if (c_valid) cv_cycles++;
      tick();
      chk("bp_hold_c_valid", 32'(c_valid), 1);
      chk("bp_hold_c_addr", 32'(c_addr), 1);
      chk("bp_hold_c_data", 32'(c_data), 32'h001B);
    end
    c_ready = 1'b1;
    if (c_valid) cv_cycles++;
    tick();
    c_ready = 1'b0;
    chk("bp_c_valid_cycles", cv_cycles, 51);
    chk("bp_c_valid_drop", 32'(c_valid), 0);
    chk("bp_tx_valid_rise", 32'(tx_valid), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_tx_valid_hold", 32'(tx_valid), 1);
      chk("bp_tx_data_hold", 32'(tx_data), 32'h06);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("bp_tx_valid_drop", 32'(tx_valid), 0);
    chk("bp_busy_idle", 32'(busy), 0);
    chk("bp_err_cnt", 32'(err_cnt), 2);

    // Timeout after the ADDR byte
    e0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h01);
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      tick();
      chk("tmo_no_tx_valid", 32'(tx_valid), 0);
    end
    chk("tmo_busy_before_expiry", 32'(busy), 1);
    tick();
    chk("tmo_busy_after_expiry", 32'(busy), 0);
    chk("tmo_err_cnt", 32'(err_cnt), 32'(e0 + 8'd1));
    chk("tmo_tx_valid", 32'(tx_valid), 0);
    c_ready = 1'b1; tx_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h1B); send_byte(8'h1A);
    chk("tmo_next_c_valid", 32'(c_valid), 1);
    chk("tmo_next_c_data", 32'(c_data), 32'h001B);
    tick();
    chk("tmo_next_ack", 32'(tx_data), 32'h06);
    tx_ready = 1'b1;
    tick();
    chk("tmo_next_idle", 32'(busy), 0);

    // A byte on the expiry cycle cancels the timeout
    e0 = err_cnt;
    send_byte(8'hA5);
    for (int i = 0; i < int'(TMO) - 1; i++) tick();
    send_byte(8'h01);
    chk("tmo_cancel_busy", 32'(busy), 1);
    send_byte(8'h00); send_byte(8'h1B); send_byte(8'h1A);
    chk("tmo_cancel_c_valid", 32'(c_valid), 1);
    chk("tmo_cancel_err", 32'(err_cnt), 32'(e0));
    tick(); tick();
    chk("tmo_cancel_idle", 32'(busy), 0);

    // Reset while a write is pending
    c_ready = 1'b0; tx_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h1B); send_byte(8'h1A);
    tick();
    chk("rstabort_pre_c_valid", 32'(c_valid), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstabort_c_valid", 32'(c_valid), 0);
    chk("rstabort_busy", 32'(busy), 0);
    chk("rstabort_err", 32'(err_cnt), 0);

    // SYNC during RESP is dropped
    c_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h1B); send_byte(8'h1A);
    tick();
    chk("drop_tx_valid", 32'(tx_valid), 1);
    send_byte(8'hA5);
    chk("drop_still_resp", 32'(tx_valid), 1);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("drop_idle", 32'(busy), 0);
    tick();
    chk("drop_not_addr", 32'(busy), 0);
    chk("drop_err", 32'(err_cnt), 0);

    // err_cnt saturation via repeated timeouts
    for (int k = 0; k < 257; k++) begin
      send_byte(8'hA5);
      for (int i = 0; i < int'(TMO) + 1; i++) tick();
    end
    chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
    chk("sat_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
